ahf_core_mailbox_v: RTL and testbench

//  Responder end of the inter-core port link used by the RISC521 cores' Read/Write/Done_in handshake.
//  One instance carries one 14-bit channel from a producer core to a consumer core through a FIFO:
//  - the producer's Write bit and Data_out feed this block; Done_wr returns to that core's Done_in bit.
//  - the consumer's Read bit feeds this block; Data_rd and Done_rd drive its Data_in slice and Done_in bit.
//  A core stalls while its request is high and the matching Done is high.

---
 rtl/ahf_core_mailbox_v.sv | 84 ++++++++
 tb/tb_ahf_core_mailbox_v.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/ahf_core_mailbox_v.sv
// rtl/ahf_core_mailbox_v.sv - FIFO mailbox responder for the Read/Write/Done_in inter-core handshake
// Outputs are registered from next state; per-side watchdog raises sticky flags on long stalls.
module ahf_core_mailbox_v #(
   parameter int WIDTH       = 14,
   parameter int DEPTH       = 8,
   parameter int STALL_LIMIT = 255,
   localparam int CW         = $clog2(DEPTH + 1)
) (
   input  logic             Clk_pin0,
   input  logic             Reset_pin,
   input  logic             Write_in,
   input  logic [WIDTH-1:0] Data_wr,
   output logic             Done_wr,
   input  logic             Read_in,
   output logic [WIDTH-1:0] Data_rd,
   output logic             Done_rd,
   output logic [CW-1:0]    Count,
   input  logic             Clr_flag,
   output logic [1:0]       Stall_flag
);

   localparam int PW = $clog2(DEPTH);
   localparam int SW = $clog2(STALL_LIMIT + 1);
   localparam logic [PW-1:0] P_ONE  = PW'(1);
   localparam logic [CW-1:0] C_ONE  = CW'(1);
   localparam logic [CW-1:0] C_FULL = CW'(DEPTH);
   localparam logic [SW-1:0] S_ONE  = SW'(1);
   localparam logic [SW-1:0] S_MAX  = SW'(STALL_LIMIT);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr, rd_ptr, wr_ptr_next, rd_ptr_next;
   logic [CW-1:0]    count_next;
   logic             acc_wr, acc_rd;
   logic [SW-1:0]    wd_wr, wd_rd, wd_wr_next, wd_rd_next;
   logic [WIDTH-1:0] head_next;

   always_comb begin
      acc_wr      = Write_in & ~Done_wr;
      acc_rd      = Read_in & ~Done_rd;
      wr_ptr_next = acc_wr ? wr_ptr + P_ONE : wr_ptr;
      rd_ptr_next = acc_rd ? rd_ptr + P_ONE : rd_ptr;
      count_next  = Count;
      if (acc_wr && !acc_rd)
         count_next = Count + C_ONE;
      else if (!acc_wr && acc_rd)
         count_next = Count - C_ONE;
      // The word being written this edge becomes the head when it lands on rd_ptr_next.
      head_next = (acc_wr && (wr_ptr == rd_ptr_next)) ? Data_wr : mem[rd_ptr_next];
      wd_wr_next = (!Write_in || acc_wr) ? '0 : ((wd_wr == S_MAX) ? S_MAX : wd_wr + S_ONE);
      wd_rd_next = (!Read_in || acc_rd) ? '0 : ((wd_rd == S_MAX) ? S_MAX : wd_rd + S_ONE);
   end

   always_ff @(posedge Clk_pin0) begin
      if (acc_wr)
         mem[wr_ptr] <= Data_wr;
   end

   always_ff @(posedge Clk_pin0 or negedge Reset_pin) begin
      if (!Reset_pin) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         Count      <= '0;
         Done_wr    <= 1'b0;
         Done_rd    <= 1'b1;
         Data_rd    <= '0;
         wd_wr      <= '0;
         wd_rd      <= '0;
         Stall_flag <= 2'b00;
      end else begin
         wr_ptr  <= wr_ptr_next;
         rd_ptr  <= rd_ptr_next;
         Count   <= count_next;
         Done_wr <= (count_next == C_FULL);
         Done_rd <= (count_next == '0);
         Data_rd <= (count_next != '0) ? head_next : '0;
         wd_wr   <= wd_wr_next;
         wd_rd   <= wd_rd_next;
         // A new set on the same edge as Clr_flag takes priority.
         Stall_flag[0] <= (wd_wr_next == S_MAX) ? 1'b1 : (Clr_flag ? 1'b0 : Stall_flag[0]);
         Stall_flag[1] <= (wd_rd_next == S_MAX) ? 1'b1 : (Clr_flag ? 1'b0 : Stall_flag[1]);
      end
   end

endmodule

// File: tb/tb_ahf_core_mailbox_v.sv
// tb/tb_ahf_core_mailbox_v.sv - self-checking bench for ahf_core_mailbox_v
// Queue-based reference model checked every cycle, plus directed literal checks.
module tb_ahf_core_mailbox_v;

   localparam int WIDTH = 14;
   localparam int DEPTH = 8;
   localparam int LIMIT = 4;
   localparam int CW    = $clog2(DEPTH + 1);

   logic             clk = 1'b0;
   logic             rst_n;
   logic             wr_in = 1'b0;
   logic [WIDTH-1:0] data_wr = '0;
   logic             done_wr;
   logic             rd_in = 1'b0;
   logic [WIDTH-1:0] data_rd;
   logic             done_rd;
   logic [CW-1:0]    count;
   logic             clr = 1'b0;
   logic [1:0]       stall_flag;

   int total = 0;
   int bad   = 0;

   int q[$];
   int w_stall = 0;
   int r_stall = 0;
   bit [1:0] m_flag = 2'b00;

   ahf_core_mailbox_v #(.WIDTH(WIDTH), .DEPTH(DEPTH), .STALL_LIMIT(LIMIT)) dut (
      .Clk_pin0   (clk),
      .Reset_pin  (rst_n),
      .Write_in   (wr_in),
      .Data_wr    (data_wr),
      .Done_wr    (done_wr),
      .Read_in    (rd_in),
      .Data_rd    (data_rd),
      .Done_rd    (done_rd),
      .Count      (count),
      .Clr_flag   (clr),
      .Stall_flag (stall_flag)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: FIFO as a queue, watchdog as a run-length of blocked cycles.
   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            q.delete();
            w_stall = 0;
            r_stall = 0;
            m_flag  = 2'b00;
         end else begin
            bit acc_w, acc_r, w_blk, r_blk;
            acc_w = wr_in && (q.size() < DEPTH);
            acc_r = rd_in && (q.size() > 0);
            w_blk = wr_in && !acc_w;
            r_blk = rd_in && !acc_r;
            if (acc_r) void'(q.pop_front());
            if (acc_w) q.push_back(int'(data_wr));
            w_stall = w_blk ? ((w_stall + 1 > LIMIT) ? LIMIT : w_stall + 1) : 0;
            r_stall = r_blk ? ((r_stall + 1 > LIMIT) ? LIMIT : r_stall + 1) : 0;
            m_flag[0] = (w_stall == LIMIT) ? 1'b1 : (clr ? 1'b0 : m_flag[0]);
            m_flag[1] = (r_stall == LIMIT) ? 1'b1 : (clr ? 1'b0 : m_flag[1]);
         end
      end
   end

   initial begin
      @(posedge clk);
      forever begin
         @(negedge clk);
         chk("count",   int'(count),      q.size());
         chk("done_wr", int'(done_wr),    int'(q.size() == DEPTH));
         chk("done_rd", int'(done_rd),    int'(q.size() == 0));
         chk("data_rd", int'(data_rd),    (q.size() > 0) ? q[0] : 0);
         chk("stall",   int'(stall_flag), int'(m_flag));
      end
   end

   task automatic cyc(input bit w, input int d, input bit r, input bit c);
      wr_in   = w;
      data_wr = WIDTH'(d);
      rd_in   = r;
      clr     = c;
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("t1_done_wr", int'(done_wr), 0);
      chk("t1_done_rd", int'(done_rd), 1);
      chk("t1_count",   int'(count), 0);
      chk("t1_data",    int'(data_rd), 0);
      chk("t1_stall",   int'(stall_flag), 0);

      cyc(1, 'h1234, 0, 0);
      chk("t2_done_rd", int'(done_rd), 0);
      chk("t2_data",    int'(data_rd), 'h1234);
      chk("t2_count",   int'(count), 1);
      cyc(0, 0, 1, 0);
      chk("t2_count0",  int'(count), 0);
      chk("t2_empty",   int'(done_rd), 1);
      chk("t2_data0",   int'(data_rd), 0);
      wr_in = 1'b0; rd_in = 1'b0;

      for (int i = 1; i <= 8; i++) cyc(1, i, 0, 0);
      chk("t3_full", int'(done_wr), 1);
      chk("t3_count8", int'(count), 8);
      for (int i = 0; i < 3; i++) begin
         cyc(1, 9, 0, 0);
         chk("t3_hold", int'(count), 8);
      end
      chk("t3_head1", int'(data_rd), 1);
      cyc(1, 9, 1, 0);
      chk("t3_count7", int'(count), 7);
      chk("t3_notfull", int'(done_wr), 0);
      chk("t3_wflag", int'(stall_flag), 1);
      cyc(1, 9, 0, 0);
      chk("t3_refill", int'(count), 8);
      for (int k = 2; k <= 9; k++) begin
         chk("t3_drain", int'(data_rd), k);
         cyc(0, 0, 1, (k == 2));
      end
      chk("t3_empty", int'(count), 0);
      chk("t3_flagclr", int'(stall_flag), 0);

      for (int i = 0; i < 3; i++) cyc(1, 100 + i, 0, 0);
      for (int i = 0; i < 4; i++) begin
         cyc(1, 103 + i, 1, 0);
         chk("t4_count3", int'(count), 3);
      end
      chk("t4_head", int'(data_rd), 104);
      for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0);

      for (int i = 1; i <= 4; i++) begin
         cyc(0, 0, 1, 0);
         chk("t5_rflag", int'(stall_flag), (i == 4) ? 2 : 0);
      end
      cyc(0, 0, 0, 0);
      chk("t5_hold", int'(stall_flag), 2);
      cyc(0, 0, 0, 1);
      chk("t5_clr", int'(stall_flag), 0);
      clr = 1'b0;

      for (int i = 0; i < 5; i++) cyc(1, 200 + i, 0, 0);
      chk("t6_count5", int'(count), 5);
      wr_in = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("t6_rst_count", int'(count), 0);
      chk("t6_rst_done_rd", int'(done_rd), 1);
      chk("t6_rst_done_wr", int'(done_wr), 0);
      chk("t6_rst_data", int'(data_rd), 0);
      #1 rst_n = 1'b1;
      @(negedge clk);
      cyc(1, 'h0ABC, 0, 0);
      chk("t6_first", int'(data_rd), 'h0ABC);
      chk("t6_count1", int'(count), 1);

      for (int i = 0; i < 600; i++) begin
         int phase;
         bit w, r;
         phase = (i / 60) % 3;
         w = (phase == 0) ? ($urandom_range(0, 9) < 8) :
             (phase == 1) ? ($urandom_range(0, 9) < 2) : $urandom_range(0, 1);
         r = (phase == 0) ? ($urandom_range(0, 9) < 2) :
             (phase == 1) ? ($urandom_range(0, 9) < 8) : $urandom_range(0, 1);
         cyc(w, int'($urandom_range(0, (1 << WIDTH) - 1)), r, ($urandom_range(0, 15) == 0));
      end
      cyc(0, 0, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
